// File: rtl/hs_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : hs_pipe_chain
// Description : Valid/ready register chain of LEN stages with bubble
//               collapsing and a registered occupancy count. LEN=0 gives a
//               combinational pass-through.
//               Optional macro HS_PIPE_CHAIN_SKID_EN adds a one-entry input
//               skid register so that in_ready comes straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_pipe_chain #(
    parameter int DW  = 8,
    parameter int LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(LEN+2)-1:0] occupancy
);

    localparam int OW = $clog2(LEN + 2);

    generate
        if (LEN == 0) begin : g_pass
            // No storage at all: the handshake is wired straight through.
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign in_ready  = out_ready;
            assign occupancy = '0;
        end else begin : g_pipe
            logic [LEN-1:0] valid_q;
            logic [LEN-1:0] valid_d;
            logic [LEN-1:0] load_w;
            logic [DW-1:0]  data_q [LEN];
            logic [DW-1:0]  data_d [LEN];
            logic [OW-1:0]  occ_q;
            logic [OW-1:0]  occ_d;
            logic           src_valid_w;
            logic [DW-1:0]  src_data_w;
            logic           accept_w;
            logic           emit_w;

            // A stage can load if it is empty or if some stage at or after it
            // is empty, or the output is being drained (bubble collapsing).
            always_comb begin : p_load
                logic carry;
                carry  = out_ready;
                load_w = '0;
                for (int i = LEN - 1; i >= 0; i--) begin
                    carry     = carry | ~valid_q[i];
                    load_w[i] = carry;
                end
            end

            assign emit_w    = valid_q[LEN-1] & out_ready;
            assign out_valid = valid_q[LEN-1];
            assign out_data  = data_q[LEN-1];
            assign occupancy = occ_q;

`ifdef HS_PIPE_CHAIN_SKID_EN
            logic          skid_valid_q;
            logic          skid_valid_d;
            logic [DW-1:0] skid_data_q;
            logic [DW-1:0] skid_data_d;
            logic          in_ready_q;

            // The skid entry, when present, always feeds stage 0 first so
            // ordering is preserved; otherwise the input bypasses it.
            assign accept_w    = in_valid & in_ready_q;
            assign src_valid_w = skid_valid_q | accept_w;
            assign src_data_w  = skid_valid_q ? skid_data_q : in_data;
            assign in_ready    = in_ready_q;

            // Capture a beat that stage 0 cannot take; release it when it can.
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (skid_valid_q) begin
                    skid_valid_d = ~load_w[0];
                end else if (accept_w && !load_w[0]) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end

            // Skid storage and the registered ready; ready stays low in reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                    in_ready_q   <= 1'b0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                    in_ready_q   <= ~skid_valid_d;
                end
            end
`else
            // Without a skid entry the input feeds stage 0 directly, so ready
            // is stage 0's load condition (masked while reset is held).
            assign accept_w    = in_valid & load_w[0] & ~rst;
            assign src_valid_w = in_valid;
            assign src_data_w  = in_data;
            assign in_ready    = load_w[0] & ~rst;
`endif

            // Shift beats forward; data registers only load real beats.
            always_comb begin
                valid_d = valid_q;
                for (int i = 0; i < LEN; i++) begin
                    data_d[i] = data_q[i];
                end
                if (load_w[0]) begin
                    valid_d[0] = src_valid_w;
                    if (src_valid_w) begin
                        data_d[0] = src_data_w;
                    end
                end
                for (int i = 1; i < LEN; i++) begin
                    if (load_w[i]) begin
                        valid_d[i] = valid_q[i-1];
                        if (valid_q[i-1]) begin
                            data_d[i] = data_q[i-1];
                        end
                    end
                end
            end

            // Occupancy tracks accepted minus emitted beats.
            always_comb begin
                occ_d = occ_q;
                if (accept_w && !emit_w) begin
                    occ_d = occ_q + OW'(1);
                end else if (!accept_w && emit_w) begin
                    occ_d = occ_q - OW'(1);
                end
            end

            // Stage registers; reset discards every held beat immediately.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= '0;
                    occ_q   <= '0;
                    for (int i = 0; i < LEN; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    occ_q   <= occ_d;
                    for (int i = 0; i < LEN; i++) begin
                        data_q[i] <= data_d[i];
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
